// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO; frames are sent back-to-back while words remain.
// Frame format is fixed at elaboration, and the baud divisor is latched at the start of each frame.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           baud_sel,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           dbg_state
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int DIV_W = $clog2(CLK_FREQ / 9600 + 1);
  localparam logic [DIV_W-1:0] DIV0 = DIV_W'(CLK_FREQ / 9600);
  localparam logic [DIV_W-1:0] DIV1 = DIV_W'(CLK_FREQ / 19200);
  localparam logic [DIV_W-1:0] DIV2 = DIV_W'(CLK_FREQ / 38400);
  localparam logic [DIV_W-1:0] DIV3 = DIV_W'(CLK_FREQ / 57600);
  localparam logic [DIV_W-1:0] DIV4 = DIV_W'(CLK_FREQ / 115200);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overflow;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic [DIV_W-1:0]       r_div;
  logic [DIV_W-1:0]       r_baud_cnt;
  logic [2:0]             r_bit_cnt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_load;
  logic                   w_baud_last;
  logic                   w_tx;
  logic                   w_tx_done;
  logic                   w_par;
  logic [DATA_BITS-1:0]   w_rd_data;
  logic [DIV_W-1:0]       w_div_sel;

  // Push handshake: a word is taken on any cycle with wr_en=1 and full=0; wr_en while full drops it.
  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = wr_en && !w_full;
  assign w_rd_data = r_mem[r_rd_ptr];
  assign w_par     = (PARITY == 1) ? ~(^w_rd_data) : (^w_rd_data);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= wr_en && w_full;
    end
  end

  always_comb begin
    case (baud_sel)
      3'd0:    w_div_sel = DIV0;
      3'd1:    w_div_sel = DIV1;
      3'd2:    w_div_sel = DIV2;
      3'd3:    w_div_sel = DIV3;
      default: w_div_sel = DIV4;
    endcase
  end

  assign w_baud_last = (r_baud_cnt == r_div - DIV_W'(1));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_tx_done    = 1'b0;
    w_tx         = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load       = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_last) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_baud_last && r_bit_cnt == BIT_LAST)
          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx = r_par;
        if (w_baud_last) w_state_next = S_STOP;
      end
      S_STOP: begin
        // Chain straight into the next start bit so the line high time is exactly the stop period.
        if (w_baud_last && r_bit_cnt == STOP_LAST) begin
          w_tx_done = 1'b1;
          if (!w_empty) begin
            w_load       = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_div      <= DIV4;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_shift    <= w_rd_data;
        r_par      <= w_par;
        r_div      <= w_div_sel;
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_baud_last) begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= (w_state_next != r_state) ? 3'd0 : r_bit_cnt + 3'd1;
          if (r_state == S_DATA) r_shift <= r_shift >> 1;
        end else begin
          r_baud_cnt <= r_baud_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign tx        = w_tx;
  assign busy      = (r_state != S_IDLE);
  assign tx_done   = w_tx_done;
  assign dbg_state = r_state;

endmodule
